// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and next-PC select encoding for the fetch stage
// Purpose: reset PC default, PC increment and the next-PC source enumeration.
// Ports: none (package).
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR
  } next_pc_sel_t;

endpackage

// File: rtl/pc_fetch_stage_if.sv
// rtl/pc_fetch_stage_if.sv - decode/imem side bus of the instruction-fetch stage
// Purpose: groups redirect controls, instruction-memory port and IF/ID outputs.
// Ports (slave = fetch stage view):
//   in : stall, branch_taken, branch_offset[15:0], branch_pc_plus4[31:0],
//        jump, jump_target[25:0], jr, jr_addr[31:0], imem_data[31:0]
//   out: imem_addr[31:0], if_instr[31:0], if_pc_plus4[31:0], if_valid, misalign
interface pc_fetch_stage_if;

  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic [31:0] branch_pc_plus4;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        misalign;

  modport master (
    output stall, branch_taken, branch_offset, branch_pc_plus4,
           jump, jump_target, jr, jr_addr, imem_data,
    input  imem_addr, if_instr, if_pc_plus4, if_valid, misalign
  );

  modport slave (
    input  stall, branch_taken, branch_offset, branch_pc_plus4,
           jump, jump_target, jr, jr_addr, imem_data,
    output imem_addr, if_instr, if_pc_plus4, if_valid, misalign
  );

endinterface

// File: rtl/mux4way32b.sv
// rtl/mux4way32b.sv - combinational 4-input 32-bit next-PC selector
// Purpose: picks one of four candidate PCs by next_pc_sel_t.
// Ports: sel_i (next_pc_sel_t), seq_i/br_i/j_i/jr_i [31:0] candidates, y_o [31:0] result.
module mux4way32b
  import cpu_pkg::*;
(
  input  next_pc_sel_t sel_i,
  input  logic [31:0]  seq_i,
  input  logic [31:0]  br_i,
  input  logic [31:0]  j_i,
  input  logic [31:0]  jr_i,
  output logic [31:0]  y_o
);

  always_comb begin
    y_o = seq_i;
    case (sel_i)
      SEL_SEQ: y_o = seq_i;
      SEL_BR:  y_o = br_i;
      SEL_J:   y_o = j_i;
      SEL_JR:  y_o = jr_i;
      default: y_o = seq_i;
    endcase
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - instruction-fetch stage: PC register, next-PC select, IF/ID register
// Purpose: holds the PC, drives imem_addr, picks next PC (jr > jump > branch > seq)
//          and registers the fetched word plus PC+4 for decode.
// Ports: clk, reset (async, active-high), bus (pc_fetch_stage_if.slave).
// Config: define PC_FETCH_DELAY_SLOT_EN for a branch delay slot (the word in IF
//         is kept on redirect instead of being squashed).
module pc_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          WIDTH    = 32
) (
  input logic             clk,
  input logic             reset,
  pc_fetch_stage_if.slave bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic             misalign_q, misalign_d;

  logic [WIDTH-1:0] seq_pc, br_pc, j_pc, jr_pc, next_pc;
  logic             redirect;
  next_pc_sel_t     sel;

  assign seq_pc   = pc_q + PC_INC;
  assign br_pc    = bus.branch_pc_plus4
                  + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
  assign j_pc     = {bus.branch_pc_plus4[31:28], bus.jump_target, 2'b00};
  assign jr_pc    = {bus.jr_addr[31:2], 2'b00};
  assign redirect = bus.jr | bus.jump | bus.branch_taken;

  always_comb begin
    sel = SEL_SEQ;
    if (bus.jr)                sel = SEL_JR;
    else if (bus.jump)         sel = SEL_J;
    else if (bus.branch_taken) sel = SEL_BR;
  end

  mux4way32b u_next_pc_mux (
    .sel_i (sel),
    .seq_i (seq_pc),
    .br_i  (br_pc),
    .j_i   (j_pc),
    .jr_i  (jr_pc),
    .y_o   (next_pc)
  );

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    // Any JR with a non-word target latches the flag, even while stalled.
    misalign_d = misalign_q | (bus.jr & (|bus.jr_addr[1:0]));
    if (redirect) begin
      // Redirect wins over stall: the PC always moves to the target.
      pc_d = next_pc;
`ifdef PC_FETCH_DELAY_SLOT_EN
      if (!bus.stall) begin
        instr_d = bus.imem_data;
        pc4_d   = seq_pc;
        valid_d = 1'b1;
      end
`else
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
`endif
    end else if (!bus.stall) begin
      pc_d    = next_pc;
      instr_d = bus.imem_data;
      pc4_d   = seq_pc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_instr    = instr_q;
  assign bus.if_pc_plus4 = pc4_q;
  assign bus.if_valid    = valid_q;
  assign bus.misalign    = misalign_q;

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined 32-bit CPU.
- Holds the program counter and drives the instruction-memory address.
- Selects the next PC from four sources: sequential, branch, jump, jump-register.
- Registers the fetched instruction and PC+4 into an IF/ID pipeline register consumed by decode. Decode's operand muxes read from that register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  decode not ready; hold PC and the IF/ID register.
- branch_taken  input  1  decode-resolved conditional branch is taken.
- branch_offset  input  16  signed word offset of the branch.
- branch_pc_plus4  input  32  PC+4 of the branch instruction, from IF/ID.
- jump  input  1  J/JAL in decode.
- jump_target  input  26  instruction index field.
- jr  input  1  JR in decode.
- jr_addr  input  32  register-sourced target.
- imem_addr  output  32  combinational, equals the PC register.
- imem_data  input  32  asynchronous-read instruction word for imem_addr.
- if_instr  output  32  registered instruction.
- if_pc_plus4  output  32  registered PC+4.
- if_valid  output  1  IF/ID register holds a live instruction.
- misalign  output  1  sticky flag: a JR target had bits[1:0] != 0.

Behaviour:
- Reset (async, active-high): pc=RESET_PC, if_instr=0, if_pc_plus4=0, if_valid=0, misalign=0. Outputs take these values immediately on assertion. First fetch happens at the first rising edge after deassertion.
- Redirect is the OR of jr, jump and branch_taken.
- Next-PC priority is jr > jump > branch_taken > sequential.
  - Sequential: pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - Branch: branch_pc_plus4 + (sign_extend(branch_offset) << 2), modulo 2^32.
  - Jump: {branch_pc_plus4[31:28], jump_target, 2'b00}.
  - JR: {jr_addr[31:2], 2'b00}. If jr_addr[1:0] != 0, misalign is set and stays 1 until reset.
- Each rising edge, in priority order:
  - If redirect: pc <= redirect target; if_valid <= 0, squashing the wrong-path word in IF. Redirect overrides stall.
  - Else if stall: pc, if_instr, if_pc_plus4 and if_valid all hold.
  - Else: pc <= pc+4; if_instr <= imem_data; if_pc_plus4 <= pc+4; if_valid <= 1.
- When if_valid=0, if_instr and if_pc_plus4 are don't-care; this implementation clears them to 0.
- Latency: one cycle from imem_addr to if_instr. Redirect penalty is one bubble.
- More than one of jr/jump/branch_taken asserted at once is legal and resolved by the priority above.
- Reset asserted mid-stall or mid-redirect: reset wins unconditionally.

Optional Feature:
- Macro: PC_FETCH_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot. On redirect, the word currently in IF is captured as a normal fetch (if_valid <= 1) while pc takes the target; no bubble.
  - A redirect coinciding with stall still loads pc but holds IF/ID unchanged.
- Undefined: squash behaviour as described in Behaviour.

Decomposition:
- Package cpu_pkg holds:
  - constants RESET_PC_DEFAULT and PC_INC=4;
  - enum next_pc_sel_t {SEL_SEQ, SEL_BR, SEL_J, SEL_JR}.
- One natural sub-module, mux4way32b: a combinational 4-input 32-bit selector indexed by next_pc_sel_t. The stage computes the select from the priority logic and feeds the four candidate PCs into it.

Test Plan:
- Reset then 4 free-running cycles, imem returns 32'hA000_0000+addr -> imem_addr 0,4,8,C; if_instr 32'hA000_0000, A000_0004, A000_0008 with if_valid=1 from edge 1; if_pc_plus4 4, 8, C.
- Branch: branch_taken=1, branch_pc_plus4=32'h10, branch_offset=16'hFFFC -> next pc=32'h0000_0000; if_valid=0 for one cycle (=1 with PC_FETCH_DELAY_SLOT_EN).
- Simultaneous jr=1 (jr_addr=32'h400) and jump=1 (target 26'h10) -> pc=32'h400; jr_addr=32'h403 -> pc=32'h400 and misalign=1, staying 1 after further cycles.
- Stall held 3 cycles at pc=32'h20 -> imem_addr, if_instr and if_valid unchanged. A jump asserted during the stall still moves pc and clears if_valid.
- Wrap: RESET_PC=32'hFFFF_FFFC -> second imem_addr=32'h0, if_pc_plus4=0.
- Async reset pulsed mid-cycle during redirect -> outputs at reset values before the next edge; fetch restarts at RESET_PC.
